// File: rtl/branch_predict_unit.sv
// Bimodal / gshare dynamic branch predictor with saturating counters.
// Define BPU_STATS_EN to build the branch and mispredict statistics counters.
module branch_predict_unit #(
  parameter int PC_WIDTH    = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_WIDTH   = 2,
  parameter int MODE        = 0
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                prediction,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic                update_predicted,
  output logic                mispredict,
  output logic                flush_IF_ID,
  output logic                flush_ID_EX,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ZERO = '0;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  =
    CTR_WIDTH'(1);

  logic                 armed_q;
  logic                 upd_fire;
  logic [IDX_W-1:0]     ghr;
  logic [IDX_W-1:0]     lookup_idx;
  logic [IDX_W-1:0]     update_idx;
  logic [CTR_WIDTH-1:0] bht_q [BHT_ENTRIES];
  logic [CTR_WIDTH-1:0] upd_ctr;
  logic [CTR_WIDTH-1:0] upd_ctr_next;
  logic                 unused_pc;

  // Updates are dropped on the first edge after reset is released.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign upd_fire = update_valid & armed_q;

  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr;
  assign update_idx = update_pc[IDX_W+1:2] ^ ghr;

  assign unused_pc = ^{lookup_pc, update_pc};

  if (MODE == 1) begin : g_gshare
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_next;

    if (IDX_W > 1) begin : g_shift
      assign ghr_next = {ghr_q[IDX_W-2:0], update_taken};
    end else begin : g_single
      assign ghr_next = update_taken;
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        ghr_q <= '0;
      end else if (upd_fire) begin
        ghr_q <= ghr_next;
      end
    end

    assign ghr = ghr_q;
  end else begin : g_bimodal
    assign ghr = '0;
  end

  assign upd_ctr = bht_q[update_idx];

  always_comb begin
    upd_ctr_next = upd_ctr;
    unique case (1'b1)
      update_taken && (upd_ctr != CTR_MAX):
        upd_ctr_next = upd_ctr + CTR_ONE;
      !update_taken && (upd_ctr != CTR_ZERO):
        upd_ctr_next = upd_ctr - CTR_ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (upd_fire) begin
      bht_q[update_idx] <= upd_ctr_next;
    end
  end

  // Read-before-write: a same-cycle update shows up next cycle.
  assign prediction = bht_q[lookup_idx][CTR_WIDTH-1];

  assign mispredict  = update_valid &
                       (update_taken ^ update_predicted);
  assign flush_IF_ID = mispredict;
  assign flush_ID_EX = mispredict;

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (upd_fire) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict &&
          (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: bimodal (64 entries)
// and gshare (16 entries) instances driven by directed vectors.
module tb_branch_predict_unit;

  localparam int S_PRED  = 0;
  localparam int S_MIS   = 1;
  localparam int S_GPRED = 2;
  localparam int S_GMIS  = 3;
  localparam int S_BCNT  = 4;
  localparam int S_MCNT  = 5;
  localparam int S_GCNT  = 6;

`ifdef BPU_STATS_EN
  localparam logic [31:0] EXP_B = 32'd10;
  localparam logic [31:0] EXP_M = 32'd3;
`else
  localparam logic [31:0] EXP_B = 32'd0;
  localparam logic [31:0] EXP_M = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;

  logic [63:0] lookup_pc;
  logic        prediction;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic        update_predicted;
  logic        mispredict;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic [63:0] g_lookup_pc;
  logic        g_pred;
  logic        g_valid;
  logic [63:0] g_pc;
  logic        g_taken;
  logic        g_predicted;
  logic        g_mis;
  logic        g_fif;
  logic        g_fex;
  logic [31:0] g_bcnt;
  logic [31:0] g_mcnt;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  branch_predict_unit u_bim (
    .clk              (clk),
    .arst_n           (arst_n),
    .lookup_pc        (lookup_pc),
    .prediction       (prediction),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_predicted (update_predicted),
    .mispredict       (mispredict),
    .flush_IF_ID      (flush_IF_ID),
    .flush_ID_EX      (flush_ID_EX),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_predict_unit #(
    .PC_WIDTH    (64),
    .BHT_ENTRIES (16),
    .CTR_WIDTH   (2),
    .MODE        (1)
  ) u_gs (
    .clk              (clk),
    .arst_n           (arst_n),
    .lookup_pc        (g_lookup_pc),
    .prediction       (g_pred),
    .update_valid     (g_valid),
    .update_pc        (g_pc),
    .update_taken     (g_taken),
    .update_predicted (g_predicted),
    .mispredict       (g_mis),
    .flush_IF_ID      (g_fif),
    .flush_ID_EX      (g_fex),
    .branch_count     (g_bcnt),
    .mispredict_count (g_mcnt)
  );

  task automatic push_exp(input int sig,
                          input logic [31:0] v,
                          input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Mispredict and both flushes must agree.
  task automatic push_mis(input logic v, input string nm);
    push_exp(S_MIS, v ? 32'd7 : 32'd0, nm);
  endtask

  task automatic push_gmis(input logic v, input string nm);
    push_exp(S_GMIS, v ? 32'd7 : 32'd0, nm);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [63:0] pc,
                     input logic t, input logic p);
    update_valid     = v;
    update_pc        = pc;
    update_taken     = t;
    update_predicted = p;
  endtask

  task automatic gupd(input logic v, input logic [63:0] pc,
                      input logic t, input logic p);
    g_valid     = v;
    g_pc        = pc;
    g_taken     = t;
    g_predicted = p;
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_PRED:  act = {31'd0, prediction};
        S_MIS:   act = {29'd0, flush_ID_EX, flush_IF_ID,
                        mispredict};
        S_GPRED: act = {31'd0, g_pred};
        S_GMIS:  act = {29'd0, g_fex, g_fif, g_mis};
        S_BCNT:  act = branch_count;
        S_MCNT:  act = mispredict_count;
        S_GCNT:  act = g_bcnt | g_mcnt;
        default: act = 32'hDEAD_BEEF;
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h, want %0h",
                 e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    lookup_pc   = '0;
    g_lookup_pc = '0;
    upd(1'b0, 64'h0, 1'b0, 1'b0);
    gupd(1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    push_exp(S_PRED, 0, "rst_pc_000");
    push_exp(S_GPRED, 0, "rst_g_pc_000");
    push_mis(1'b0, "rst_mis");
    push_gmis(1'b0, "rst_gmis");
    push_exp(S_BCNT, 0, "rst_bcnt");
    push_exp(S_MCNT, 0, "rst_mcnt");
    step;
    lookup_pc = 64'h100; g_lookup_pc = 64'h100;
    push_exp(S_PRED, 0, "rst_pc_100");
    push_exp(S_GPRED, 0, "rst_g_pc_100");
    step;
    lookup_pc = 64'hFFC; g_lookup_pc = 64'hFFC;
    push_exp(S_PRED, 0, "rst_pc_ffc");
    push_exp(S_GPRED, 0, "rst_g_pc_ffc");

    // Bimodal training and saturation at 0x40.
    step;
    upd(1'b1, 64'h40, 1'b1, 1'b0);
    lookup_pc = 64'h40;
    push_exp(S_PRED, 0, "pre_train");
    push_mis(1'b1, "mis_first");
    step;
    upd(1'b1, 64'h40, 1'b1, 1'b0);
    push_exp(S_PRED, 1, "ctr_10");
    push_mis(1'b1, "mis_second");
    step;
    upd(1'b0, 64'h40, 1'b1, 1'b0);
    push_exp(S_PRED, 1, "ctr_11");
    push_mis(1'b0, "no_valid_no_mis");
    step;
    upd(1'b1, 64'h40, 1'b1, 1'b1);
    push_mis(1'b0, "correct_pred");
    step;
    upd(1'b1, 64'h40, 1'b1, 1'b1);
    step;
    upd(1'b1, 64'h40, 1'b0, 1'b1);
    push_mis(1'b1, "mis_not_taken");
    step;
    upd(1'b0, 64'h40, 1'b0, 1'b0);
    push_exp(S_PRED, 1, "sat_hi");
    step;
    upd(1'b1, 64'h40, 1'b0, 1'b1);
    step;
    upd(1'b0, 64'h40, 1'b0, 1'b0);
    push_exp(S_PRED, 0, "dec_to_01");

    // Same-cycle lookup/update hit.
    step;
    upd(1'b1, 64'h80, 1'b1, 1'b0);
    lookup_pc = 64'h80;
    push_exp(S_PRED, 0, "rbw_same");
    step;
    upd(1'b0, 64'h80, 1'b0, 1'b0);
    push_exp(S_PRED, 1, "rbw_next");

    // Aliasing on index 1.
    step;
    upd(1'b1, 64'h04, 1'b1, 1'b0);
    step;
    upd(1'b1, 64'h04, 1'b1, 1'b0);
    step;
    upd(1'b0, 64'h04, 1'b0, 1'b0);
    lookup_pc = 64'h104;
    push_exp(S_PRED, 1, "alias_104");
    step;
    lookup_pc = 64'h08;
    push_exp(S_PRED, 0, "alias_08");

    // Saturation at zero.
    for (int i = 0; i < 3; i++) begin
      step;
      upd(1'b1, 64'h0C, 1'b0, 1'b0);
    end
    step;
    upd(1'b1, 64'h0C, 1'b1, 1'b0);
    step;
    upd(1'b0, 64'h0C, 1'b0, 1'b0);
    lookup_pc = 64'h0C;
    push_exp(S_PRED, 0, "sat_lo");

    // gshare: ghr 0001, 0011, 0110, then 1101.
    step;
    gupd(1'b1, 64'h10, 1'b1, 1'b0);
    g_lookup_pc = 64'h10;
    push_exp(S_GPRED, 0, "gs_pre");
    push_gmis(1'b1, "gs_mis1");
    step;
    gupd(1'b0, 64'h10, 1'b0, 1'b0);
    g_lookup_pc = 64'h14;
    push_exp(S_GPRED, 1, "gs_ghr_0001");
    push_gmis(1'b0, "gs_no_valid");
    step;
    gupd(1'b1, 64'h10, 1'b1, 1'b1);
    push_gmis(1'b0, "gs_mis2");
    step;
    gupd(1'b0, 64'h10, 1'b0, 1'b0);
    g_lookup_pc = 64'h18;
    push_exp(S_GPRED, 1, "gs_ghr_0011");
    step;
    gupd(1'b1, 64'h10, 1'b0, 1'b0);
    push_gmis(1'b0, "gs_mis3");
    step;
    gupd(1'b0, 64'h10, 1'b0, 1'b0);
    g_lookup_pc = 64'h08;
    push_exp(S_GPRED, 1, "gs_ghr_0110_e4");
    step;
    g_lookup_pc = 64'h0C;
    push_exp(S_GPRED, 1, "gs_e5");
    step;
    gupd(1'b1, 64'h04, 1'b1, 1'b0);
    g_lookup_pc = 64'h04;
    push_exp(S_GPRED, 0, "gs_e7_rbw");
    push_gmis(1'b1, "gs_mis4");
    step;
    gupd(1'b0, 64'h04, 1'b0, 1'b0);
    g_lookup_pc = 64'h28;
    push_exp(S_GPRED, 0, "gs_e7_dec");

    // Half-cycle reset pulse with updates pending.
    step;
    upd(1'b1, 64'h04, 1'b1, 1'b1);
    lookup_pc = 64'h04;
    push_exp(S_PRED, 1, "pre_rst_bim");
    push_mis(1'b0, "pre_rst_mis");
    gupd(1'b1, 64'h10, 1'b1, 1'b1);
    g_lookup_pc = 64'h24;
    push_exp(S_GPRED, 1, "pre_rst_gs");
    @(negedge clk);
    #2 arst_n = 1'b0;
    #5 arst_n = 1'b1;
    g_lookup_pc = 64'h10;
    push_exp(S_PRED, 0, "rst_bim_cleared");
    push_exp(S_GPRED, 0, "rst_gs_cleared");
    push_exp(S_BCNT, 0, "rst_mid_bcnt");
    push_exp(S_MCNT, 0, "rst_mid_mcnt");
    step;
    upd(1'b0, 64'h04, 1'b0, 1'b0);
    gupd(1'b0, 64'h10, 1'b0, 1'b0);
    g_lookup_pc = 64'h14;
    push_exp(S_PRED, 0, "release_ignored");
    push_exp(S_GPRED, 0, "release_ignored_gs");
    push_exp(S_BCNT, 0, "release_bcnt");
    push_exp(S_GCNT, 0, "release_gcnt");

    // Statistics: 10 updates, 3 mispredicts.
    for (int i = 0; i < 10; i++) begin
      step;
      upd(1'b1, 64'h200, 1'b1, (i < 3) ? 1'b0 : 1'b1);
      push_mis((i < 3) ? 1'b1 : 1'b0, "stat_mis");
    end
    step;
    upd(1'b0, 64'h200, 1'b0, 1'b0);
    push_exp(S_BCNT, EXP_B, "branch_count");
    push_exp(S_MCNT, EXP_M, "mispredict_count");
    push_mis(1'b0, "idle_mis");

    step;
    step;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      n_bad += sb_q.size();
      $display("FAIL drain: %0d unchecked, want 0",
               sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
